// File: rtl/follower_pkg.sv
// Shared definitions for the Follower barcode path: decoder states, frame
// length and the station-ID header rule.
package follower_pkg;

    // Decoder states, in frame order.
    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_FALL,
        DLY,
        CHECK
    } bc_state_t;

    // Data bits per frame, sent MSB first.
    localparam int unsigned BC_BITS = 8;

    // Header bits that must read zero for the station ID to be accepted.
    localparam logic [7:0] ID_HDR_MASK = 8'hC0;

    // True when the captured byte carries a legal station-ID header.
    function automatic logic id_ok(input logic [7:0] id);
        return (id & ID_HDR_MASK) == 8'h00;
    endfunction

endpackage

// File: rtl/bc_sync.sv
// Synchronizer for an asynchronous, idle-high serial line.
// Two metastability flops followed by a history flop; fall/rise are single
// cycle pulses derived from the history and synchronized values. Also used
// by the command RX path.
module bc_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic fall,
    output logic rise
);

    logic meta;
    logic hist;

    // Synchronizer chain and history; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            hist <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            hist <= sync;
        end
    end

    assign fall = hist & ~sync;
    assign rise = ~hist & sync;

endmodule

// File: rtl/barcode_decoder.sv
// Serial station-ID barcode decoder.
// The start bit low time calibrates the bit period; each data bit is sampled
// period+1 cycles after its falling edge, MSB first. A frame whose header bits
// are clear updates ID and sets the sticky ID_vld; any other frame, or a start
// bit that saturates the timer, pulses frame_err for one cycle.
// Optional build macro: BARCODE_TIMEOUT_EN adds an inter-edge gap timeout of
// TO_MULT x period while waiting for or sampling data bits.
module barcode_decoder
    import follower_pkg::*;
#(
    parameter int unsigned PER_W   = 22,
    parameter int unsigned TO_MULT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld,
    output logic       frame_err
);

    if (TO_MULT == 0) begin : g_to_mult_range
        $error("TO_MULT must be at least 1");
    end

    bc_state_t        state;
    bc_state_t        state_next;

    logic [PER_W-1:0] timer;
    logic [PER_W-1:0] period;
    logic [7:0]       shift;
    logic [3:0]       bit_cnt;

    logic             sync;
    logic             fall;
    logic             rise;

    logic             timer_sat;
    logic             timer_one;
    logic             timer_clr;
    logic             timer_inc;
    logic             period_cap;
    logic             sample;
    logic             accept;
    logic             reject;
    logic             gap_over;

    bc_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (BC),
        .sync (sync),
        .fall (fall),
        .rise (rise)
    );

    assign timer_sat = (timer == '1);

`ifdef BARCODE_TIMEOUT_EN
    localparam int unsigned GAP_W = PER_W + $clog2(TO_MULT + 1);

    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_lim;

    assign gap_lim  = GAP_W'(period) * GAP_W'(TO_MULT);
    assign gap_over = (gap > gap_lim);

    // Free-running cycles since the last falling edge, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap <= '0;
        end else if (fall) begin
            gap <= '0;
        end else if (gap != '1) begin
            gap <= gap + GAP_W'(1);
        end
    end
`else
    assign gap_over = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_next = state;
        timer_one  = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        period_cap = 1'b0;
        sample     = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    // The fall cycle is already the first low cycle of the
                    // start bit, so the shortest start bit measures 1.
                    timer_one  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (rise) begin
                    period_cap = 1'b1;
                    state_next = WAIT_FALL;
                end else if (timer_sat) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (gap_over) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end else if (fall) begin
                    timer_clr  = 1'b1;
                    state_next = DLY;
                end
            end
            DLY: begin
                if (gap_over) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_inc = ~timer_sat;
                    if (timer == period) begin
                        sample     = 1'b1;
                        state_next = (bit_cnt == 4'(BC_BITS - 1)) ? CHECK : WAIT_FALL;
                    end
                end
            end
            CHECK: begin
                if (id_ok(shift)) begin
                    accept = 1'b1;
                end else begin
                    reject = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit timer, measured period, shift register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            period  <= '0;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            if (timer_one) begin
                timer <= PER_W'(1);
            end else if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + PER_W'(1);
            end

            if (period_cap) begin
                period  <= timer;
                bit_cnt <= '0;
            end else if (sample) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (sample) begin
                shift <= {shift[6:0], sync};
            end
        end
    end

    // Result registers: ID holds until the next good frame; a set of ID_vld
    // takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ID        <= '0;
            ID_vld    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= reject;
            if (accept) begin
                ID     <= shift;
                ID_vld <= 1'b1;
            end else if (clr_ID_vld) begin
                ID_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_barcode_decoder.sv
// Self-checking bench for barcode_decoder. Frames are built as line waveforms
// (start bit of L low cycles, 0 bit = 2L low + 2 high, 1 bit = 2 low + L+2
// high); the reference predicts each frame's outcome and the cycle at which it
// takes effect, and one process compares the outputs on every cycle.
module tb_barcode_decoder;

    localparam int PER_W   = 22;
    localparam int TO_MULT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       BC = 1'b1;
    logic       clr_ID_vld = 1'b0;
    logic [7:0] ID;
    logic       ID_vld;
    logic       frame_err;

    barcode_decoder #(
        .PER_W   (PER_W),
        .TO_MULT (TO_MULT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int clr_from = -1;
    int clr_to   = -1;
    bit rand_clr = 1'b0;

    // Predicted frame outcome: takes effect at the clock edge ending cycle 'at'.
    typedef struct {
        int         at;
        bit         good;
        logic [7:0] id;
    } result_t;

    result_t    pending[$];
    logic [7:0] m_id  = 8'h00;
    logic       m_vld = 1'b0;
    logic       m_err = 1'b0;
    bit         m_set;

    // Reference: result registers updated from predicted frame outcomes.
    always @(posedge clk) begin
        cyc   = cyc + 1;
        m_err = 1'b0;
        m_set = 1'b0;
        if (rst) begin
            m_id  = 8'h00;
            m_vld = 1'b0;
            pending.delete();
        end else begin
            for (int i = 0; i < pending.size(); i++) begin
                if (pending[i].at == cyc - 1) begin
                    if (pending[i].good) begin
                        m_id  = pending[i].id;
                        m_set = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            if (m_set) m_vld = 1'b1;
            else if (clr_ID_vld) m_vld = 1'b0;
        end
    end

    // Per-cycle comparison of all outputs against the reference.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            checks++;
            if (ID !== m_id || ID_vld !== m_vld || frame_err !== m_err) begin
                errors++;
                $display("FAIL outputs cyc=%0d: ID=%h ID_vld=%b frame_err=%b, expected ID=%h ID_vld=%b frame_err=%b",
                         cyc, ID, ID_vld, frame_err, m_id, m_vld, frame_err === 1'bx ? 1'bx : m_err);
            end
        end
    end

    // Observation of pulse counts, ID_vld rise time and ID history.
    int         err_pulses  = 0;
    int         vld_rise_at = -1;
    logic       vld_q       = 1'b0;
    logic [7:0] id_q        = 8'h00;
    logic [7:0] id_hist[$];

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
        if (ID_vld === 1'b1 && vld_q !== 1'b1) vld_rise_at = cyc;
        vld_q = ID_vld;
        if (ID !== id_q) id_hist.push_back(ID);
        id_q = ID;
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive the line for one cycle; the values apply to cycle 'cyc'.
    task automatic tick(input logic bc_val);
        @(posedge clk);
        #1;
        BC = bc_val;
        clr_ID_vld = (cyc >= clr_from && cyc <= clr_to) ||
                     (rand_clr && $urandom_range(0, 39) == 0);
    endtask

    task automatic idle_until(input int n);
        while (cyc < n) tick(1'b1);
    endtask

    // Send a frame. A fall driven in cycle d is seen by the decoder in d+2,
    // sampled in d+L+3, and the CHECK cycle is d+L+4 for the last bit.
    task automatic send_frame(input logic [7:0] data, input int L, input int nbits,
                              input int gap_after, input int gap_len,
                              input bit clr_at_check, output int chk);
        int  d;
        int  lo;
        int  hi;
        logic bitv;
        chk = cyc;
        for (int i = 0; i < L; i++) tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        for (int b = 0; b < nbits; b++) begin
            bitv = data[7 - b];
            lo   = bitv ? 2 : 2 * L;
            hi   = bitv ? L + 2 : 2;
            if (b == gap_after) hi += gap_len;
            tick(1'b0);
            d = cyc;
`ifdef BARCODE_TIMEOUT_EN
            if (b == gap_after && gap_len > 0) begin
                chk = d + TO_MULT * L + 4;
                pending.push_back('{chk, 1'b0, 8'h00});
                for (int i = 1; i < lo; i++) tick(1'b0);
                for (int i = 0; i < hi; i++) tick(1'b1);
                return;
            end
`endif
            if (b == 7) begin
                chk = d + L + 4;
                pending.push_back('{chk, data[7:6] == 2'b00, data});
                if (clr_at_check) begin
                    clr_from = chk;
                    clr_to   = chk + 1;
                end
            end
            for (int i = 1; i < lo; i++) tick(1'b0);
            for (int i = 0; i < hi; i++) tick(1'b1);
        end
    endtask

    initial begin
        int chk;
        int chk2;
        int e0;
        int L;
        logic [7:0] data;

        rst = 1'b1;
        repeat (3) tick(1'b1);
        rst = 1'b0;
        check_eq("reset_ID", ID, 8'h00);
        check_eq("reset_ID_vld", ID_vld, 1'b0);
        check_eq("reset_frame_err", frame_err, 1'b0);
        repeat (4) tick(1'b1);

        // Long start bit, 0 bits held low 0x1000.
        e0 = err_pulses;
        send_frame(8'h15, 'h800, 8, -1, 0, 1'b0, chk);
        idle_until(chk + 4);
        check_eq("f15_ID", ID, 8'h15);
        check_eq("f15_vld_rise_cycle", vld_rise_at, chk + 1);
        check_eq("f15_no_frame_err", err_pulses - e0, 0);

        // Plain clear.
        clr_from = cyc + 1;
        clr_to   = cyc + 1;
        repeat (3) tick(1'b1);
        check_eq("clr_ID_vld", ID_vld, 1'b0);
        check_eq("clr_keeps_ID", ID, 8'h15);

        // Bad header.
        e0 = err_pulses;
        send_frame(8'hC3, 20, 8, -1, 0, 1'b0, chk);
        idle_until(chk + 4);
        check_eq("fC3_one_err_pulse", err_pulses - e0, 1);
        check_eq("fC3_ID_unchanged", ID, 8'h15);
        check_eq("fC3_ID_vld", ID_vld, 1'b0);

        // Clear coincident with CHECK, then again the next cycle.
        send_frame(8'h2A, 24, 8, -1, 0, 1'b1, chk);
        idle_until(chk + 4);
        check_eq("f2A_set_wins_rise", vld_rise_at, chk + 1);
        check_eq("f2A_cleared_after", ID_vld, 1'b0);
        check_eq("f2A_ID", ID, 8'h2A);

        // Reset mid-frame.
        e0 = err_pulses;
        send_frame(8'h11, 16, 4, -1, 0, 1'b0, chk);
        repeat (30) tick(1'b1);
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        repeat (3) tick(1'b1);
        check_eq("rst_ID", ID, 8'h00);
        send_frame(8'h07, 16, 8, -1, 0, 1'b0, chk);
        idle_until(chk + 4);
        check_eq("f07_ID", ID, 8'h07);
        check_eq("rst_no_frame_err", err_pulses - e0, 0);

        // Short period, back-to-back frames.
        send_frame(8'h3F, 16, 8, -1, 0, 1'b0, chk);
        send_frame(8'h01, 16, 8, -1, 0, 1'b0, chk2);
        idle_until(chk2 + 4);
        check_eq("b2b_ID", ID, 8'h01);
        check_eq("b2b_first_decoded", id_hist[id_hist.size() - 2], 8'h3F);
        check_eq("b2b_second_after_first", chk2 > chk, 1'b1);

        // Long idle gap after bit 3.
        e0 = err_pulses;
        send_frame(8'h25, 'h100, 8, 3, 'h401, 1'b0, chk);
        idle_until(chk + 4);
`ifdef BARCODE_TIMEOUT_EN
        check_eq("gap_timeout_err", err_pulses - e0, 1);
        check_eq("gap_ID_unchanged", ID, 8'h01);
`else
        check_eq("gap_no_err", err_pulses - e0, 0);
        check_eq("gap_ID", ID, 8'h25);
`endif

        // Randomized frames with random clears.
        rand_clr = 1'b1;
        repeat (10) begin
            L    = $urandom_range(4, 40);
            data = 8'($urandom);
            send_frame(data, L, 8, -1, 0, 1'b0, chk);
            repeat ($urandom_range(0, 6)) tick(1'b1);
        end
        rand_clr = 1'b0;
        idle_until(cyc + 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d, expected completion", cyc);
        $fatal(1);
    end

endmodule
